// File: rtl/inv_keyexpansion.sv
// Byte-serial AES-128 inverse key schedule: loads round key 10, emits rounds 10..0
// one byte per cycle and derives each previous round key in place with one S-box.
module inv_keyexpansion (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       key_in_valid,
    output logic       load_ready,
    input  logic       round_req,
    output logic       req_ready,
    output logic [7:0] key_out,
    output logic       key_valid,
    output logic [3:0] key_round,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READY, S_EMIT, S_UPDATE, S_DONE
    } state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    // Round constant used when stepping from round r back to round r-1.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] round_q, round_d;
    logic [7:0] key_q [16];
    logic [7:0] key_d [16];
    logic [7:0] key_out_q, key_out_d;
    logic       key_valid_q, key_valid_d;
    logic       req_ready_q, req_ready_d;
    logic       load_ready_q, load_ready_d;
    logic       done_q, done_d;

    logic [1:0] rot_row;
    logic [7:0] sub_byte;
    logic [3:0] upd_dst;
    logic [3:0] upd_src;

    // Update cycles 0..11 fold w3, w2, w1 (in that order, so each reads the old
    // lower word); cycles 12..15 rebuild w0 from SubWord(RotWord(w3')).
    assign rot_row  = cnt_q[1:0] + 2'd1;
    assign sub_byte = sbox(key_q[{2'b11, rot_row}]);
    assign upd_dst  = {~cnt_q[3:2], cnt_q[1:0]};
    assign upd_src  = upd_dst - 4'd4;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        round_d     = round_q;
        key_d       = key_q;
        key_out_d   = 8'h00;
        key_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_in_valid) begin
                    key_d[0] = key_in;
                    cnt_d    = 4'd1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (key_in_valid) begin
                    key_d[cnt_q] = key_in;
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        round_d = 4'd10;
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (round_req) begin
                    key_out_d   = key_q[0];
                    key_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (cnt_q != 4'd15) begin
                    key_out_d   = key_q[cnt_q + 4'd1];
                    key_valid_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = (round_q == 4'd0) ? S_DONE : S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (cnt_q < 4'd12) begin
                    key_d[upd_dst] = key_q[upd_dst] ^ key_q[upd_src];
                end else begin
                    key_d[{2'b00, cnt_q[1:0]}] = key_q[{2'b00, cnt_q[1:0]}] ^ sub_byte
                        ^ ((cnt_q[1:0] == 2'd0) ? rcon(round_q) : 8'h00);
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    round_d = round_q - 4'd1;
                    state_d = S_READY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_READY);
        load_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            round_q      <= 4'd0;
            key_out_q    <= 8'h00;
            key_valid_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            load_ready_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            round_q      <= round_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
            req_ready_q  <= req_ready_d;
            load_ready_q <= load_ready_d;
            done_q       <= done_d;
        end
    end

    // NOTE: the key register has no reset; every load rewrites it and it only reaches key_out while valid.
    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    assign key_out    = key_out_q;
    assign key_valid  = key_valid_q;
    assign key_round  = round_q;
    assign req_ready  = req_ready_q;
    assign load_ready = load_ready_q;
    assign done       = done_q;

endmodule
